mvb_item_serializer: RTL and testbench
======================================

// Module: mvb_item_serializer
// PURPOSE
//  Consumes the multi-item MVB stream leaving MVB_PIPE and re-emits it as a single-item MVB stream.
//  Emits one valid item per cycle, in ascending item index order.
//  Buffers one RX word; drops all-invalid words; honours TX backpressure.
//  Sits between MVB_PIPE and single-item consumers (e.g. per-item lookup/FIFO stages).
// PARAMETERS
//  ITEMS       4   items per RX MVB word (>=1)
//  ITEM_WIDTH  8   bits per item (>=1)
// PORTS
//  CLK         in   1                 clock; all logic rising-edge
//  RESET       in   1                 asynchronous, active-high reset
//  RX_DATA     in   ITEMS*ITEM_WIDTH  item i at bits [(i+1)*ITEM_WIDTH-1 : i*ITEM_WIDTH]
//  RX_VLD      in   ITEMS             per-item valid
//  RX_SRC_RDY  in   1                 RX word offered
//  RX_DST_RDY  out  1                 RX word accepted when RX_SRC_RDY=RX_DST_RDY=1
//  TX_DATA     out  ITEM_WIDTH        current output item
//  TX_VLD      out  1                 item valid (always equal to TX_SRC_RDY)
//  TX_SRC_RDY  out  1                 item offered
//  TX_DST_RDY  in   1                 item transferred when TX_SRC_RDY=TX_DST_RDY=1
// BEHAVIOUR
//  - State: data_reg (ITEMS*ITEM_WIDTH) and pend_mask (ITEMS), the not-yet-sent valid items.
//  - RESET asserted (async): pend_mask=0, data_reg=0.
//    Outputs: TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, RX_DST_RDY=0.
//    RX_DST_RDY is forced low for as long as RESET is high.
//  - sel = index of lowest set bit in pend_mask.
//  - TX_DATA = data_reg item[sel]; TX_DATA=0 when pend_mask=0.
//  - TX_SRC_RDY = TX_VLD = OR(pend_mask).
//  - tx_xfer = TX_SRC_RDY & TX_DST_RDY.
//    On tx_xfer, clear bit sel of pend_mask at the clock edge.
//  - last = popcount(pend_mask) <= 1.
//  - RX_DST_RDY = !RESET & (pend_mask==0 | (last & TX_DST_RDY)).
//    This is a combinational path from TX_DST_RDY; it gives full throughput for 1-item words.
//  - rx_xfer = RX_SRC_RDY & RX_DST_RDY.
//    On rx_xfer: data_reg<=RX_DATA; pend_mask<=RX_VLD.
//    Load takes priority over the bit-clear from a simultaneous last-item tx_xfer.
//  - rx_xfer with RX_VLD=0: word consumed, pend_mask stays 0, nothing emitted.
//  - Latency: an item accepted at edge N is first offered on TX in the cycle after edge N.
//  - Throughput: a word with K valid items occupies TX for exactly K transfer cycles (no bubbles).
//    With TX_DST_RDY=1 throughout, the next word loads on the edge of the last transfer.
//  - TX_DST_RDY=0: TX_DATA/TX_SRC_RDY held stable, pend_mask unchanged.
//  - Data-item values are not modified; item order is preserved within and across words.
//  - Reset mid-word: pending items are discarded; none are emitted after reset release.
//  - No state other than data_reg/pend_mask; no FSM beyond the mask (empty/busy/last).
// TESTING
//  - ITEMS=4. Word VLD=1111, items A,B,C,D; TX_DST_RDY=1.
//    -> TX emits A,B,C,D on 4 consecutive cycles; RX_DST_RDY=1 only in the D cycle.
//  - VLD=0101 (items 0,2 = 0x11,0x33), then VLD=1000 (item3=0x44), back-to-back, TX_DST_RDY=1.
//    -> TX emits 0x11,0x33,0x44 on 3 consecutive cycles, no bubble.
//  - VLD=0000 word with SRC_RDY=1.
//    -> accepted in 1 cycle, TX_SRC_RDY stays 0; the following word is accepted the next cycle.
//  - VLD=0011, TX_DST_RDY=0 for 5 cycles, then 1.
//    -> TX_DATA=item0 stable for 5 cycles, RX_DST_RDY=0 throughout; then item0, item1 transferred.
//  - RESET pulsed after item0 of VLD=1111 is sent.
//    -> TX_SRC_RDY=0 and RX_DST_RDY=0 immediately (async).
//    -> after release, RX_DST_RDY=1 and items 1..3 are never emitted.
//  - Random VLD/SRC_RDY/DST_RDY, 10k words.
//    -> scoreboard: TX item sequence equals RX valid items in index order; TX_VLD==TX_SRC_RDY.

Source files
------------

// File: rtl/mvb_item_serializer.sv
// rtl/mvb_item_serializer.sv - multi-item MVB to single-item MVB serializer
module mvb_item_serializer #(
    parameter int ITEMS      = 4,
    parameter int ITEM_WIDTH = 8
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [ITEMS*ITEM_WIDTH-1:0] RX_DATA,
    input  logic [ITEMS-1:0]            RX_VLD,
    input  logic                        RX_SRC_RDY,
    output logic                        RX_DST_RDY,
    output logic [ITEM_WIDTH-1:0]       TX_DATA,
    output logic                        TX_VLD,
    output logic                        TX_SRC_RDY,
    input  logic                        TX_DST_RDY
);
    localparam int SEL_W = (ITEMS > 1) ? $clog2(ITEMS) : 1;
    localparam logic [ITEMS-1:0] MASK_ONE = ITEMS'(1);

    logic [ITEMS*ITEM_WIDTH-1:0] data_reg;
    logic [ITEMS-1:0]            pend_mask;
    logic [SEL_W-1:0]            sel;
    logic                        busy;
    logic                        last;
    logic                        tx_xfer;
    logic                        rx_xfer;

    // Lowest pending index wins, so items leave in ascending order.
    always_comb begin
        sel = '0;
        for (int i = ITEMS - 1; i >= 0; i--) begin
            if (pend_mask[i]) sel = SEL_W'(i);
        end
    end

    assign busy    = |pend_mask;
    assign last    = (pend_mask & (pend_mask - MASK_ONE)) == '0;
    assign tx_xfer = busy & TX_DST_RDY;

    // Accept a new word while the final pending item is leaving: no bubble between words.
    assign RX_DST_RDY = !RESET & (!busy | (last & TX_DST_RDY));
    assign rx_xfer    = RX_SRC_RDY & RX_DST_RDY;

    assign TX_SRC_RDY = busy;
    assign TX_VLD     = busy;
    assign TX_DATA    = busy ? data_reg[int'(sel)*ITEM_WIDTH +: ITEM_WIDTH] : '0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_reg  <= '0;
            pend_mask <= '0;
        end else if (rx_xfer) begin
            data_reg  <= RX_DATA;
            pend_mask <= RX_VLD;
        end else if (tx_xfer) begin
            pend_mask[sel] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mvb_item_serializer.sv
// tb/tb_mvb_item_serializer.sv - self-checking bench for mvb_item_serializer
module tb_mvb_item_serializer;
    localparam int ITEMS = 4;
    localparam int W     = 8;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic [ITEMS*W-1:0] RX_DATA = '0;
    logic [ITEMS-1:0] RX_VLD = '0;
    logic             RX_SRC_RDY = 1'b0;
    logic             RX_DST_RDY;
    logic [W-1:0]     TX_DATA;
    logic             TX_VLD;
    logic             TX_SRC_RDY;
    logic             TX_DST_RDY = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mvb_item_serializer #(.ITEMS(ITEMS), .ITEM_WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET),
        .RX_DATA(RX_DATA), .RX_VLD(RX_VLD), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
        .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET = 1'b1; RX_SRC_RDY = 1'b1; RX_VLD = '1; TX_DST_RDY = 1'b1;
        tick; tick; #1;
        n_cmp++; if (TX_SRC_RDY !== 1'b0) begin n_err++; $display("FAIL reset_src_rdy: got %b want 0", TX_SRC_RDY); end
        n_cmp++; if (TX_VLD !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", TX_VLD); end
        n_cmp++; if (TX_DATA !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", TX_DATA); end
        n_cmp++; if (RX_DST_RDY !== 1'b0) begin n_err++; $display("FAIL reset_dst_rdy: got %b want 0", RX_DST_RDY); end
        RX_SRC_RDY = 1'b0; RX_VLD = '0; RESET = 1'b0; #1;
        n_cmp++; if (RX_DST_RDY !== 1'b1) begin n_err++; $display("FAIL reset_release_dst_rdy: got %b want 1", RX_DST_RDY); end
        n_cmp++; if (TX_SRC_RDY !== 1'b0) begin n_err++; $display("FAIL reset_release_src_rdy: got %b want 0", TX_SRC_RDY); end
    endtask

    task automatic test_full_word;
        logic [W-1:0] it [ITEMS];
        for (int i = 0; i < ITEMS; i++) it[i] = W'($urandom);
        tick;
        RX_DATA = {it[3], it[2], it[1], it[0]}; RX_VLD = 4'b1111; RX_SRC_RDY = 1'b1; TX_DST_RDY = 1'b1; #1;
        n_cmp++; if (RX_DST_RDY !== 1'b1) begin n_err++; $display("FAIL full_accept: got %b want 1", RX_DST_RDY); end
        tick; RX_SRC_RDY = 1'b0; #1;
        for (int k = 0; k < ITEMS; k++) begin
            n_cmp++; if (TX_SRC_RDY !== 1'b1) begin n_err++; $display("FAIL full_src_rdy[%0d]: got %b want 1", k, TX_SRC_RDY); end
            n_cmp++; if (TX_DATA !== it[k]) begin n_err++; $display("FAIL full_data[%0d]: got %h want %h", k, TX_DATA, it[k]); end
            n_cmp++; if (RX_DST_RDY !== (k == ITEMS - 1)) begin n_err++; $display("FAIL full_dst_rdy[%0d]: got %b want %b", k, RX_DST_RDY, k == ITEMS - 1); end
            tick; #1;
        end
        n_cmp++; if (TX_SRC_RDY !== 1'b0) begin n_err++; $display("FAIL full_drained: got %b want 0", TX_SRC_RDY); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h33; exp_seq[2] = 8'h44;
        tick;
        RX_DATA = 32'hEE33_DD11; RX_VLD = 4'b0101; RX_SRC_RDY = 1'b1; TX_DST_RDY = 1'b1;
        tick;
        RX_DATA = 32'h44CC_BBAA; RX_VLD = 4'b1000; #1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin RX_SRC_RDY = 1'b0; #1; end
            n_cmp++; if (TX_SRC_RDY !== 1'b1) begin n_err++; $display("FAIL b2b_src_rdy[%0d]: got %b want 1", k, TX_SRC_RDY); end
            n_cmp++; if (TX_DATA !== exp_seq[k]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, TX_DATA, exp_seq[k]); end
            if (k < 2) begin
                n_cmp++; if (RX_DST_RDY !== (k == 1)) begin n_err++; $display("FAIL b2b_dst_rdy[%0d]: got %b want %b", k, RX_DST_RDY, k == 1); end
            end
            tick;
        end
        #1;
        n_cmp++; if (TX_SRC_RDY !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", TX_SRC_RDY); end
    endtask

    task automatic test_empty_word;
        tick;
        RX_DATA = 32'hDEAD_BEEF; RX_VLD = 4'b0000; RX_SRC_RDY = 1'b1; TX_DST_RDY = 1'b1; #1;
        n_cmp++; if (RX_DST_RDY !== 1'b1) begin n_err++; $display("FAIL empty_accept: got %b want 1", RX_DST_RDY); end
        tick;
        RX_DATA = 32'h0000_005A; RX_VLD = 4'b0001; #1;
        n_cmp++; if (TX_SRC_RDY !== 1'b0) begin n_err++; $display("FAIL empty_no_emit: got %b want 0", TX_SRC_RDY); end
        n_cmp++; if (RX_DST_RDY !== 1'b1) begin n_err++; $display("FAIL empty_next_accept: got %b want 1", RX_DST_RDY); end
        tick; RX_SRC_RDY = 1'b0; #1;
        n_cmp++; if (TX_DATA !== 8'h5A || TX_SRC_RDY !== 1'b1) begin n_err++; $display("FAIL empty_next_data: got %h/%b want 5a/1", TX_DATA, TX_SRC_RDY); end
        tick; #1;
        n_cmp++; if (TX_SRC_RDY !== 1'b0) begin n_err++; $display("FAIL empty_drained: got %b want 0", TX_SRC_RDY); end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] a, b;
        a = W'($urandom); b = W'($urandom);
        tick;
        RX_DATA = {16'h0000, b, a}; RX_VLD = 4'b0011; RX_SRC_RDY = 1'b1; TX_DST_RDY = 1'b0;
        tick;
        RX_DATA = 32'h7777_7777; RX_VLD = 4'b1111; #1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (TX_DATA !== a || TX_SRC_RDY !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: got %h/%b want %h/1", k, TX_DATA, TX_SRC_RDY, a); end
            n_cmp++; if (RX_DST_RDY !== 1'b0) begin n_err++; $display("FAIL bp_dst_rdy[%0d]: got %b want 0", k, RX_DST_RDY); end
            tick; #1;
        end
        RX_SRC_RDY = 1'b0; TX_DST_RDY = 1'b1; #1;
        n_cmp++; if (TX_DATA !== a) begin n_err++; $display("FAIL bp_item0: got %h want %h", TX_DATA, a); end
        tick; #1;
        n_cmp++; if (TX_DATA !== b || TX_SRC_RDY !== 1'b1) begin n_err++; $display("FAIL bp_item1: got %h/%b want %h/1", TX_DATA, TX_SRC_RDY, b); end
        n_cmp++; if (RX_DST_RDY !== 1'b1) begin n_err++; $display("FAIL bp_last_dst_rdy: got %b want 1", RX_DST_RDY); end
        tick; #1;
        n_cmp++; if (TX_SRC_RDY !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", TX_SRC_RDY); end
    endtask

    task automatic test_reset_midword;
        tick;
        RX_DATA = 32'h4433_2211; RX_VLD = 4'b1111; RX_SRC_RDY = 1'b1; TX_DST_RDY = 1'b1;
        tick; RX_SRC_RDY = 1'b0; #1;
        n_cmp++; if (TX_DATA !== 8'h11) begin n_err++; $display("FAIL rstmid_item0: got %h want 11", TX_DATA); end
        tick;
        RX_SRC_RDY = 1'b1; RX_VLD = 4'b0000; RESET = 1'b1; #1;
        n_cmp++; if (TX_SRC_RDY !== 1'b0) begin n_err++; $display("FAIL rstmid_src_rdy: got %b want 0", TX_SRC_RDY); end
        n_cmp++; if (RX_DST_RDY !== 1'b0) begin n_err++; $display("FAIL rstmid_dst_rdy: got %b want 0", RX_DST_RDY); end
        RX_SRC_RDY = 1'b0;
        tick; tick;
        RESET = 1'b0; #1;
        n_cmp++; if (RX_DST_RDY !== 1'b1) begin n_err++; $display("FAIL rstmid_release_dst_rdy: got %b want 1", RX_DST_RDY); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (TX_SRC_RDY !== 1'b0) begin n_err++; $display("FAIL rstmid_no_emit[%0d]: got %b/%h want 0", k, TX_SRC_RDY, TX_DATA); end
            tick;
        end
    endtask

    task automatic test_random;
        logic [W-1:0]       q [$];
        logic [W-1:0]       exp_item;
        logic [ITEMS*W-1:0] d;
        logic [ITEMS-1:0]   v;
        logic               exp_rdy;
        int                 words = 0;
        int                 cycles = 0;
        d = $urandom; v = ITEMS'($urandom);
        while ((words < 10000 || q.size() != 0) && cycles < 80000) begin
            tick;
            RX_DATA = d; RX_VLD = v;
            RX_SRC_RDY = (words < 10000) && ($urandom_range(0, 7) != 0);
            TX_DST_RDY = ($urandom_range(0, 7) != 0);
            #1;
            n_cmp++; if (TX_VLD !== TX_SRC_RDY) begin n_err++; $display("FAIL rnd_vld_eq_src: got %b want %b", TX_VLD, TX_SRC_RDY); end
            n_cmp++; if (TX_SRC_RDY !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_src_rdy: got %b want %b", TX_SRC_RDY, q.size() != 0); end
            exp_rdy = (q.size() == 0) || (q.size() == 1 && TX_DST_RDY);
            n_cmp++; if (RX_DST_RDY !== exp_rdy) begin n_err++; $display("FAIL rnd_dst_rdy: got %b want %b", RX_DST_RDY, exp_rdy); end
            if (TX_SRC_RDY && TX_DST_RDY && q.size() != 0) begin
                exp_item = q.pop_front();
                n_cmp++; if (TX_DATA !== exp_item) begin n_err++; $display("FAIL rnd_data: got %h want %h", TX_DATA, exp_item); end
            end
            if (RX_SRC_RDY && RX_DST_RDY) begin
                for (int i = 0; i < ITEMS; i++) if (v[i]) q.push_back(d[i*W +: W]);
                words++;
                d = $urandom; v = ITEMS'($urandom);
            end
            cycles++;
        end
        n_cmp++; if (cycles >= 80000) begin n_err++; $display("FAIL rnd_timeout: words %0d pending %0d want 10000/0", words, q.size()); end
        RX_SRC_RDY = 1'b0; TX_DST_RDY = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_empty_word();
        test_backpressure();
        test_reset_midword();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
